// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, field widths, channel indices
// into the per-channel register mask, and the skid buffer state encoding.
package axi4_lite_pkg;

    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Bit positions inside REG_MASK; bit set = channel is registered.
    localparam int CH_AW  = 0;
    localparam int CH_W   = 1;
    localparam int CH_B   = 2;
    localparam int CH_AR  = 3;
    localparam int CH_R   = 4;
    localparam int NUM_CH = 5;

    // Occupancy of one skid buffer: nothing held, output register only,
    // output register plus skid register.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/axi4_lite_skid_buffer.sv
// Two-entry skid buffer. Breaks the valid/data path and the ready path between
// its two sides while still moving one beat per cycle.
//
// Handshake: a beat moves on a side when its valid and ready are both high at
// a rising clock edge. A producer holds valid and data until that happens;
// in_ready and out_valid here are both flops, so no combinational path runs
// from out_ready to in_ready or from in_valid to out_valid.
module axi4_lite_skid_buffer
    import axi4_lite_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output skid_state_t      dbg_state
);

    skid_state_t      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_push;
    logic w_pop;
    logic w_load_out_from_in;
    logic w_load_out_from_skid;
    logic w_load_skid;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // The output register takes a fresh input beat when it is free or being
    // drained in the same cycle; in FULL it refills from the skid register.
    assign w_load_out_from_skid = (r_state == SKID_FULL) & w_pop;
    assign w_load_out_from_in   = w_push &
                                  ((r_state == SKID_EMPTY) |
                                   ((r_state == SKID_ONE) & w_pop));
    assign w_load_skid          = w_push & (r_state == SKID_ONE) & ~w_pop;

    // Occupancy FSM with registered in_ready/out_valid; reset empties the buffer
    // and holds in_ready low until the first edge after release.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_push) begin
                        r_state     <= SKID_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_push && !w_pop) begin
                        r_state    <= SKID_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_push && w_pop) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                SKID_FULL: begin
                    if (w_pop) begin
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload registers: no reset, loaded only when a beat moves in or shifts.
    always_ff @(posedge clk) begin
        if (w_load_out_from_skid) begin
            r_out_data <= r_skid_data;
        end else if (w_load_out_from_in) begin
            r_out_data <= in_data;
        end
        if (w_load_skid) begin
            r_skid_data <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign dbg_state = r_state;

endmodule

// File: rtl/axi4_lite_slave_reg_slice.sv
// AXI4-Lite register slice between a master-side port (s_*) and a slave DUT
// port (m_*). Each of the five channels is either a skid buffer or a plain
// wire, selected by REG_MASK bit order {R,AR,B,W,AW}.
module axi4_lite_slave_reg_slice
    import axi4_lite_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] REG_MASK   = 5'b11111
) (
    input  logic                    clk,
    input  logic                    arst_n,
    // Master-facing side
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [PROT_W-1:0]       s_awprot,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [RESP_W-1:0]       s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [PROT_W-1:0]       s_arprot,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [RESP_W-1:0]       s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    // DUT-facing side
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [PROT_W-1:0]       m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [RESP_W-1:0]       m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [PROT_W-1:0]       m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [RESP_W-1:0]       m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    // Per-channel skid state, 2 bits each in CH_* order; bypass reads EMPTY
    output logic [2*NUM_CH-1:0]     o_dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AX_W   = ADDR_WIDTH + PROT_W;
    localparam int W_W    = DATA_WIDTH + STRB_W;
    localparam int B_W    = RESP_W;
    localparam int R_W    = DATA_WIDTH + RESP_W;

    // clk/arst_n have no load when every channel is bypassed.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, arst_n};

    generate
        // AW: master to DUT, payload {addr,prot}
        if (REG_MASK[CH_AW]) begin : g_aw_reg
            logic [AX_W-1:0] w_out;
            skid_state_t     w_state;
            axi4_lite_skid_buffer #(.WIDTH(AX_W)) u_skid (
                .clk       (clk),
                .arst_n    (arst_n),
                .in_valid  (s_awvalid),
                .in_ready  (s_awready),
                .in_data   ({s_awaddr, s_awprot}),
                .out_valid (m_awvalid),
                .out_ready (m_awready),
                .out_data  (w_out),
                .dbg_state (w_state)
            );
            assign {m_awaddr, m_awprot}         = w_out;
            assign o_dbg_state[2*CH_AW +: 2]    = w_state;
        end else begin : g_aw_byp
            assign m_awaddr                     = s_awaddr;
            assign m_awprot                     = s_awprot;
            assign m_awvalid                    = s_awvalid;
            assign s_awready                    = m_awready;
            assign o_dbg_state[2*CH_AW +: 2]    = SKID_EMPTY;
        end

        // W: master to DUT, payload {data,strb}
        if (REG_MASK[CH_W]) begin : g_w_reg
            logic [W_W-1:0] w_out;
            skid_state_t    w_state;
            axi4_lite_skid_buffer #(.WIDTH(W_W)) u_skid (
                .clk       (clk),
                .arst_n    (arst_n),
                .in_valid  (s_wvalid),
                .in_ready  (s_wready),
                .in_data   ({s_wdata, s_wstrb}),
                .out_valid (m_wvalid),
                .out_ready (m_wready),
                .out_data  (w_out),
                .dbg_state (w_state)
            );
            assign {m_wdata, m_wstrb}           = w_out;
            assign o_dbg_state[2*CH_W +: 2]     = w_state;
        end else begin : g_w_byp
            assign m_wdata                      = s_wdata;
            assign m_wstrb                      = s_wstrb;
            assign m_wvalid                     = s_wvalid;
            assign s_wready                     = m_wready;
            assign o_dbg_state[2*CH_W +: 2]     = SKID_EMPTY;
        end

        // B: DUT to master, payload {resp}
        if (REG_MASK[CH_B]) begin : g_b_reg
            logic [B_W-1:0] w_out;
            skid_state_t    w_state;
            axi4_lite_skid_buffer #(.WIDTH(B_W)) u_skid (
                .clk       (clk),
                .arst_n    (arst_n),
                .in_valid  (m_bvalid),
                .in_ready  (m_bready),
                .in_data   (m_bresp),
                .out_valid (s_bvalid),
                .out_ready (s_bready),
                .out_data  (w_out),
                .dbg_state (w_state)
            );
            assign s_bresp                      = w_out;
            assign o_dbg_state[2*CH_B +: 2]     = w_state;
        end else begin : g_b_byp
            assign s_bresp                      = m_bresp;
            assign s_bvalid                     = m_bvalid;
            assign m_bready                     = s_bready;
            assign o_dbg_state[2*CH_B +: 2]     = SKID_EMPTY;
        end

        // AR: master to DUT, payload {addr,prot}
        if (REG_MASK[CH_AR]) begin : g_ar_reg
            logic [AX_W-1:0] w_out;
            skid_state_t     w_state;
            axi4_lite_skid_buffer #(.WIDTH(AX_W)) u_skid (
                .clk       (clk),
                .arst_n    (arst_n),
                .in_valid  (s_arvalid),
                .in_ready  (s_arready),
                .in_data   ({s_araddr, s_arprot}),
                .out_valid (m_arvalid),
                .out_ready (m_arready),
                .out_data  (w_out),
                .dbg_state (w_state)
            );
            assign {m_araddr, m_arprot}         = w_out;
            assign o_dbg_state[2*CH_AR +: 2]    = w_state;
        end else begin : g_ar_byp
            assign m_araddr                     = s_araddr;
            assign m_arprot                     = s_arprot;
            assign m_arvalid                    = s_arvalid;
            assign s_arready                    = m_arready;
            assign o_dbg_state[2*CH_AR +: 2]    = SKID_EMPTY;
        end

        // R: DUT to master, payload {data,resp}
        if (REG_MASK[CH_R]) begin : g_r_reg
            logic [R_W-1:0] w_out;
            skid_state_t    w_state;
            axi4_lite_skid_buffer #(.WIDTH(R_W)) u_skid (
                .clk       (clk),
                .arst_n    (arst_n),
                .in_valid  (m_rvalid),
                .in_ready  (m_rready),
                .in_data   ({m_rdata, m_rresp}),
                .out_valid (s_rvalid),
                .out_ready (s_rready),
                .out_data  (w_out),
                .dbg_state (w_state)
            );
            assign {s_rdata, s_rresp}           = w_out;
            assign o_dbg_state[2*CH_R +: 2]     = w_state;
        end else begin : g_r_byp
            assign s_rdata                      = m_rdata;
            assign s_rresp                      = m_rresp;
            assign s_rvalid                     = m_rvalid;
            assign m_rready                     = s_rready;
            assign o_dbg_state[2*CH_R +: 2]     = SKID_EMPTY;
        end
    endgenerate

endmodule

// File: tb/tb_axi4_lite_slave_reg_slice.sv
// Bench for axi4_lite_slave_reg_slice: a fully registered instance and a fully
// bypassed instance share the same stimulus. The registered one is checked
// against per-channel FIFO queues of capacity two; the bypassed one against
// plain same-cycle equality.
module tb_axi4_lite_slave_reg_slice;
    import axi4_lite_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    // ---------------- DUT inputs (shared) ----------------
    logic [31:0] s_awaddr;  logic [2:0] s_awprot;  logic s_awvalid;
    logic [31:0] s_wdata;   logic [3:0] s_wstrb;   logic s_wvalid;
    logic        s_bready;
    logic [31:0] s_araddr;  logic [2:0] s_arprot;  logic s_arvalid;
    logic        s_rready;
    logic        m_awready, m_wready, m_arready;
    logic [1:0]  m_bresp;   logic m_bvalid;
    logic [31:0] m_rdata;   logic [1:0] m_rresp;   logic m_rvalid;

    // ---------------- registered DUT outputs ----------------
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [31:0] m_awaddr, m_araddr, m_wdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic [9:0]  dbg_state;

    // ---------------- bypass DUT outputs ----------------
    logic        bp_s_awready, bp_s_wready, bp_s_arready, bp_s_bvalid, bp_s_rvalid;
    logic [1:0]  bp_s_bresp, bp_s_rresp;
    logic [31:0] bp_s_rdata;
    logic [31:0] bp_m_awaddr, bp_m_araddr, bp_m_wdata;
    logic [2:0]  bp_m_awprot, bp_m_arprot;
    logic [3:0]  bp_m_wstrb;
    logic        bp_m_awvalid, bp_m_wvalid, bp_m_arvalid, bp_m_bready, bp_m_rready;
    logic [9:0]  bp_dbg_state;

    axi4_lite_slave_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_MASK(5'b11111)) dut (
        .clk(clk), .arst_n(arst_n),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .o_dbg_state(dbg_state)
    );

    axi4_lite_slave_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_MASK(5'b00000)) dut_byp (
        .clk(clk), .arst_n(arst_n),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(bp_s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(bp_s_wready),
        .s_bresp(bp_s_bresp), .s_bvalid(bp_s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(bp_s_arready),
        .s_rdata(bp_s_rdata), .s_rresp(bp_s_rresp), .s_rvalid(bp_s_rvalid), .s_rready(s_rready),
        .m_awaddr(bp_m_awaddr), .m_awprot(bp_m_awprot), .m_awvalid(bp_m_awvalid), .m_awready(m_awready),
        .m_wdata(bp_m_wdata), .m_wstrb(bp_m_wstrb), .m_wvalid(bp_m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(bp_m_bready),
        .m_araddr(bp_m_araddr), .m_arprot(bp_m_arprot), .m_arvalid(bp_m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(bp_m_rready),
        .o_dbg_state(bp_dbg_state)
    );

    // ---------------- per-channel views ----------------
    // "in" is the producer side of a channel, "out" the consumer side.
    logic        ch_in_valid [5], ch_in_ready [5], ch_out_valid [5], ch_out_ready [5];
    logic [63:0] ch_in_data  [5], ch_out_data [5];
    logic        bp_in_ready [5], bp_out_valid [5];
    logic [63:0] bp_out_data [5];
    string       ch_name [5] = '{"aw", "w", "b", "ar", "r"};

    always_comb begin
        ch_in_valid[0]  = s_awvalid;  ch_in_ready[0] = s_awready;  ch_in_data[0]  = 64'({s_awaddr, s_awprot});
        ch_out_valid[0] = m_awvalid;  ch_out_ready[0] = m_awready; ch_out_data[0] = 64'({m_awaddr, m_awprot});
        bp_in_ready[0]  = bp_s_awready; bp_out_valid[0] = bp_m_awvalid; bp_out_data[0] = 64'({bp_m_awaddr, bp_m_awprot});

        ch_in_valid[1]  = s_wvalid;   ch_in_ready[1] = s_wready;   ch_in_data[1]  = 64'({s_wdata, s_wstrb});
        ch_out_valid[1] = m_wvalid;   ch_out_ready[1] = m_wready;  ch_out_data[1] = 64'({m_wdata, m_wstrb});
        bp_in_ready[1]  = bp_s_wready; bp_out_valid[1] = bp_m_wvalid; bp_out_data[1] = 64'({bp_m_wdata, bp_m_wstrb});

        ch_in_valid[2]  = m_bvalid;   ch_in_ready[2] = m_bready;   ch_in_data[2]  = 64'(m_bresp);
        ch_out_valid[2] = s_bvalid;   ch_out_ready[2] = s_bready;  ch_out_data[2] = 64'(s_bresp);
        bp_in_ready[2]  = bp_m_bready; bp_out_valid[2] = bp_s_bvalid; bp_out_data[2] = 64'(bp_s_bresp);

        ch_in_valid[3]  = s_arvalid;  ch_in_ready[3] = s_arready;  ch_in_data[3]  = 64'({s_araddr, s_arprot});
        ch_out_valid[3] = m_arvalid;  ch_out_ready[3] = m_arready; ch_out_data[3] = 64'({m_araddr, m_arprot});
        bp_in_ready[3]  = bp_s_arready; bp_out_valid[3] = bp_m_arvalid; bp_out_data[3] = 64'({bp_m_araddr, bp_m_arprot});

        ch_in_valid[4]  = m_rvalid;   ch_in_ready[4] = m_rready;   ch_in_data[4]  = 64'({m_rdata, m_rresp});
        ch_out_valid[4] = s_rvalid;   ch_out_ready[4] = s_rready;  ch_out_data[4] = 64'({s_rdata, s_rresp});
        bp_in_ready[4]  = bp_m_rready; bp_out_valid[4] = bp_s_rvalid; bp_out_data[4] = 64'({bp_s_rdata, bp_s_rresp});
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q [5][$];
    logic        ready_ok;      // false from reset until the first edge after release
    logic        last_push [5];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int ch = 0; ch < 5; ch++) begin
            exp_q[ch].delete();
            last_push[ch] = 1'b0;
        end
        ready_ok = 1'b0;
    endtask

    // One clock: check everything on the falling edge, advance the model on the
    // rising edge, return 1 time unit later so callers can drive new inputs.
    task automatic cycle();
        logic        push [5];
        logic        pop  [5];
        logic [63:0] pd   [5];
        @(negedge clk);
        for (int ch = 0; ch < 5; ch++) begin
            check({ch_name[ch], "_in_ready"}, 64'(ch_in_ready[ch]),
                  64'(ready_ok && (exp_q[ch].size() < 2)));
            check({ch_name[ch], "_out_valid"}, 64'(ch_out_valid[ch]), 64'(exp_q[ch].size() > 0));
            if (exp_q[ch].size() > 0)
                check({ch_name[ch], "_out_data"}, ch_out_data[ch], exp_q[ch][0]);
            check({ch_name[ch], "_occupancy"}, 64'(dbg_state[2*ch +: 2]), 64'(exp_q[ch].size()));
            check({ch_name[ch], "_byp_valid"}, 64'(bp_out_valid[ch]), 64'(ch_in_valid[ch]));
            check({ch_name[ch], "_byp_ready"}, 64'(bp_in_ready[ch]), 64'(ch_out_ready[ch]));
            check({ch_name[ch], "_byp_data"}, bp_out_data[ch], ch_in_data[ch]);
            push[ch] = ch_in_valid[ch] & ch_in_ready[ch];
            pop[ch]  = ch_out_valid[ch] & ch_out_ready[ch];
            pd[ch]   = ch_in_data[ch];
        end
        check("byp_dbg_state", 64'(bp_dbg_state), 64'd0);
        @(posedge clk);
        if (!arst_n) begin
            clear_model();
        end else begin
            for (int ch = 0; ch < 5; ch++) begin
                if (pop[ch] && exp_q[ch].size() > 0) void'(exp_q[ch].pop_front());
                if (push[ch]) exp_q[ch].push_back(pd[ch]);
                last_push[ch] = push[ch];
            end
            ready_ok = 1'b1;
        end
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_ch(input int ch, input logic v, input logic [63:0] d);
        case (ch)
            0: begin s_awvalid = v; {s_awaddr, s_awprot} = d[34:0]; end
            1: begin s_wvalid  = v; {s_wdata, s_wstrb}   = d[35:0]; end
            2: begin m_bvalid  = v; m_bresp              = d[1:0];  end
            3: begin s_arvalid = v; {s_araddr, s_arprot} = d[34:0]; end
            default: begin m_rvalid = v; {m_rdata, m_rresp} = d[33:0]; end
        endcase
    endtask

    task automatic set_ready(input int ch, input logic r);
        case (ch)
            0: m_awready = r;
            1: m_wready  = r;
            2: s_bready  = r;
            3: m_arready = r;
            default: s_rready = r;
        endcase
    endtask

    task automatic idle_all(input logic r);
        for (int ch = 0; ch < 5; ch++) begin
            drive_ch(ch, 1'b0, 64'd0);
            set_ready(ch, r);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        arst_n = 1'b0;
        clear_model();
        idle_all(1'b0);

        // Reset release: readies rise on the first edge after release.
        cycle();
        cycle();
        arst_n = 1'b1;
        cycle();
        for (int ch = 0; ch < 5; ch++) begin
            check({ch_name[ch], "_ready_after_rst"}, 64'(ch_in_ready[ch]), 64'd1);
            check({ch_name[ch], "_valid_after_rst"}, 64'(ch_out_valid[ch]), 64'd0);
        end

        // Single AW beat: visible exactly one cycle after the push, for one cycle.
        set_ready(0, 1'b1);
        drive_ch(0, 1'b1, 64'({32'h0000_0010, 3'b000}));
        cycle();
        drive_ch(0, 1'b0, 64'd0);
        check("aw_single_valid", 64'(m_awvalid), 64'd1);
        check("aw_single_addr", 64'(m_awaddr), 64'h10);
        check("aw_single_prot", 64'(m_awprot), 64'd0);
        cycle();
        check("aw_single_gone", 64'(m_awvalid), 64'd0);

        // W burst of 8 back-to-back beats with no bubbles.
        set_ready(1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            drive_ch(1, 1'b1, 64'({k[31:0], 4'hF}));
            cycle();
            check($sformatf("w_burst_valid_%0d", k), 64'(m_wvalid), 64'd1);
            check($sformatf("w_burst_data_%0d", k), 64'(m_wdata), 64'(k));
            check($sformatf("w_burst_strb_%0d", k), 64'(m_wstrb), 64'hF);
        end
        drive_ch(1, 1'b0, 64'd0);
        cycle();
        check("w_burst_end", 64'(m_wvalid), 64'd0);

        // R backpressure: two beats fill the buffer, master stalls three cycles.
        set_ready(4, 1'b0);
        drive_ch(4, 1'b1, 64'({32'hA5A5_A5A5, OKAY}));
        cycle();
        check("r_bp_ready_one", 64'(m_rready), 64'd1);
        check("r_bp_data_one", 64'(s_rdata), 64'hA5A5_A5A5);
        drive_ch(4, 1'b1, 64'({32'h5A5A_5A5A, OKAY}));
        cycle();
        check("r_bp_ready_full", 64'(m_rready), 64'd0);
        check("r_bp_data_held", 64'(s_rdata), 64'hA5A5_A5A5);
        drive_ch(4, 1'b0, 64'd0);
        cycle();
        check("r_bp_still_full", 64'(m_rready), 64'd0);
        set_ready(4, 1'b1);
        cycle();
        check("r_bp_second_data", 64'(s_rdata), 64'h5A5A_5A5A);
        check("r_bp_second_resp", 64'(s_rresp), 64'(OKAY));
        check("r_bp_ready_back", 64'(m_rready), 64'd1);
        cycle();
        check("r_bp_drained", 64'(s_rvalid), 64'd0);

        // Reset asserted while B is FULL: bvalid drops without waiting for a clock.
        set_ready(2, 1'b0);
        drive_ch(2, 1'b1, 64'(SLVERR));
        cycle();
        drive_ch(2, 1'b1, 64'(DECERR));
        cycle();
        drive_ch(2, 1'b0, 64'd0);
        check("b_full_valid", 64'(s_bvalid), 64'd1);
        check("b_full_ready", 64'(m_bready), 64'd0);
        #2;
        arst_n = 1'b0;
        #1;
        check("b_rst_async_valid", 64'(s_bvalid), 64'd0);
        check("b_rst_async_ready", 64'(m_bready), 64'd0);
        clear_model();
        cycle();
        arst_n = 1'b1;
        set_ready(2, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("b_no_stale_%0d", i), 64'(s_bvalid), 64'd0);
        end

        // Random traffic on all channels; valid is held until accepted.
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < 5; ch++) begin
                if (!(ch_in_valid[ch] && !last_push[ch]))
                    drive_ch(ch, 1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
                set_ready(ch, 1'($urandom_range(0, 3) != 0));
            end
            cycle();
        end

        // Drain: everything still buffered must come out.
        for (int n = 0; n < 6; n++) begin
            for (int ch = 0; ch < 5; ch++) begin
                if (!(ch_in_valid[ch] && !last_push[ch]))
                    drive_ch(ch, 1'b0, 64'd0);
                set_ready(ch, 1'b1);
            end
            cycle();
        end
        for (int ch = 0; ch < 5; ch++)
            check({ch_name[ch], "_drained"}, 64'(ch_out_valid[ch]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
